// File: rtl/seq_div_frac.sv
// Radix-2 restoring sequential divider: quotient = floor((dividend << FRAC) / divisor), one bit per clock.
// Optional macro SEQ_DIV_ROUND_EN adds half-up rounding of the final quotient (no extra cycles).
module seq_div_frac #(
    parameter int DW   = 16,
    parameter int QW   = 16,
    parameter int FRAC = 8
) (
    input  logic          clk,
    input  logic          nrst,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [DW-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic [QW-1:0] quotient,
    output logic [DW-1:0] remainder,
    output logic          div_zero,
    output logic          overflow
);

    localparam int N  = DW + FRAC;
    localparam int CW = $clog2(N + 1);
    // Wide enough to hold the (possibly rounded) full quotient and to test the bits above QW.
    localparam int QX = (N + 1 > QW) ? N + 1 : QW + 1;

    typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

    state_t        state, state_nxt;
    logic [N-1:0]  e_q, e_nxt;
    logic [DW-1:0] r_q, r_nxt;
    logic [N-2:0]  qf_q, qf_nxt;
    logic [CW-1:0] cnt_q, cnt_nxt;
    logic [DW-1:0] dsr_q, dsr_nxt;
    logic [QW-1:0] quo_nxt;
    logic [DW-1:0] rem_nxt;
    logic          dz_nxt, ovf_nxt;

    logic [DW:0]   t;
    logic          ge;
    logic [DW-1:0] r_step;
    logic [N-1:0]  q_step;
    logic [N:0]    q_fin;
    logic          last;

    // Clamp the full quotient to QW bits; MSB of the result is the overflow flag.
    function automatic logic [QW:0] saturate(input logic [QX-1:0] q);
        if ((q >> QW) != '0)
            return {1'b1, {QW{1'b1}}};
        return {1'b0, q[QW-1:0]};
    endfunction

    // One restoring step; the remainder after a step is always below divisor so it fits DW bits.
    always_comb begin
        t      = {r_q, e_q[N-1]};
        ge     = (t >= {1'b0, dsr_q});
        r_step = ge ? DW'(t - {1'b0, dsr_q}) : t[DW-1:0];
        q_step = {qf_q, ge};
        last   = (cnt_q == CW'(N - 1));
`ifdef SEQ_DIV_ROUND_EN
        q_fin  = {1'b0, q_step} + (N+1)'({1'b0, r_step, 1'b0} >= {2'b00, dsr_q});
`else
        q_fin  = {1'b0, q_step};
`endif
    end

    always_comb begin
        state_nxt = state;
        e_nxt     = e_q;
        r_nxt     = r_q;
        qf_nxt    = qf_q;
        cnt_nxt   = cnt_q;
        dsr_nxt   = dsr_q;
        quo_nxt   = quotient;
        rem_nxt   = remainder;
        dz_nxt    = div_zero;
        ovf_nxt   = overflow;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    dsr_nxt = divisor;
                    e_nxt   = N'(dividend) << FRAC;
                    r_nxt   = '0;
                    qf_nxt  = '0;
                    cnt_nxt = '0;
                    if (divisor != '0) begin
                        state_nxt = DIV;
                    end else begin
                        state_nxt = DONE;
                        quo_nxt   = '1;
                        rem_nxt   = dividend;
                        dz_nxt    = 1'b1;
                        ovf_nxt   = 1'b0;
                    end
                end else if (state == DONE) begin
                    state_nxt = IDLE;
                end
            end
            DIV: begin
                e_nxt   = e_q << 1;
                r_nxt   = r_step;
                qf_nxt  = q_step[N-2:0];
                cnt_nxt = cnt_q + CW'(1);
                if (last) begin
                    state_nxt          = DONE;
                    {ovf_nxt, quo_nxt} = saturate(QX'(q_fin));
                    rem_nxt            = r_step;
                    dz_nxt             = 1'b0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state     <= IDLE;
            e_q       <= '0;
            r_q       <= '0;
            qf_q      <= '0;
            cnt_q     <= '0;
            dsr_q     <= '0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            state     <= state_nxt;
            e_q       <= e_nxt;
            r_q       <= r_nxt;
            qf_q      <= qf_nxt;
            cnt_q     <= cnt_nxt;
            dsr_q     <= dsr_nxt;
            quotient  <= quo_nxt;
            remainder <= rem_nxt;
            div_zero  <= dz_nxt;
            overflow  <= ovf_nxt;
        end
    end

    assign busy = (state == DIV);
    assign done = (state == DONE);

endmodule

// File: tb/tb_seq_div_frac.sv
// Randomised bench for seq_div_frac against a cycle-counting arithmetic model, plus directed literal cases.
module tb_seq_div_frac;

    localparam int DW   = 16;
    localparam int QW   = 16;
    localparam int FRAC = 8;
    localparam int N    = DW + FRAC;

    logic          clk = 1'b0;
    logic          nrst = 1'b0;
    logic          start = 1'b0;
    logic [DW-1:0] dividend = '0;
    logic [DW-1:0] divisor = '0;
    logic          busy, done, div_zero, overflow;
    logic [QW-1:0] quotient;
    logic [DW-1:0] remainder;

    int n_chk = 0;
    int n_fail = 0;
    int n_done = 0;
    bit cmp_en = 1'b0;

    seq_div_frac #(.DW(DW), .QW(QW), .FRAC(FRAC)) dut (
        .clk(clk), .nrst(nrst), .start(start), .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
        .div_zero(div_zero), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic: {overflow, quotient}.
    function automatic logic [QW:0] model_qo(input logic [DW-1:0] a, input logic [DW-1:0] b);
        longint num, q, r;
        num = longint'(a) << FRAC;
        q = num / longint'(b);
        r = num % longint'(b);
`ifdef SEQ_DIV_ROUND_EN
        if (2 * r >= longint'(b)) q++;
`endif
        if (q > longint'({QW{1'b1}})) return {1'b1, {QW{1'b1}}};
        return {1'b0, q[QW-1:0]};
    endfunction

    function automatic logic [DW-1:0] model_rem(input logic [DW-1:0] a, input logic [DW-1:0] b);
        longint num;
        num = longint'(a) << FRAC;
        return DW'(num % longint'(b));
    endfunction

    // Model: an accepted operation finishes N edges later; divide-by-zero finishes on the accepting edge.
    int            m_left;
    logic          m_busy, m_done, m_dz, m_ov, p_ov;
    logic [QW-1:0] m_q, p_q;
    logic [DW-1:0] m_r, p_r;

    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            m_left <= 0;
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_q    <= '0;
            m_r    <= '0;
            m_dz   <= 1'b0;
            m_ov   <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (m_left != 0) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                    m_q    <= p_q;
                    m_r    <= p_r;
                    m_ov   <= p_ov;
                    m_dz   <= 1'b0;
                end
            end else if (start) begin
                if (divisor == '0) begin
                    m_done <= 1'b1;
                    m_q    <= '1;
                    m_r    <= dividend;
                    m_dz   <= 1'b1;
                    m_ov   <= 1'b0;
                end else begin
                    {p_ov, p_q} <= model_qo(dividend, divisor);
                    p_r         <= model_rem(dividend, divisor);
                    m_left      <= N;
                    m_busy      <= 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("busy", busy, m_busy);
            chk("done", done, m_done);
            chk("quotient", quotient, m_q);
            chk("remainder", remainder, m_r);
            chk("div_zero", div_zero, m_dz);
            chk("overflow", overflow, m_ov);
            if (done) n_done++;
        end
    end

    // Directed operation with literal expectations; lat counts edges after the accepting edge.
    task automatic run_op(input string nm, input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic [QW-1:0] eq, input logic [DW-1:0] er,
                          input logic edz, input logic eov, input int elat);
        int k;
        @(negedge clk);
        start = 1'b1; dividend = a; divisor = b;
        @(negedge clk);
        start = 1'b0;
        chk({nm, "_busy"}, busy, (b != 0));
        k = 0;
        while (!done && k < 60) begin
            @(negedge clk);
            k++;
        end
        chk({nm, "_lat"}, k, elat);
        chk({nm, "_q"}, quotient, eq);
        chk({nm, "_r"}, remainder, er);
        chk({nm, "_dz"}, div_zero, edz);
        chk({nm, "_ov"}, overflow, eov);
    endtask

    task automatic wait_done(output int k);
        k = 0;
        while (!done && k < 60) begin
            @(negedge clk);
            k++;
        end
    endtask

    initial begin
        int k;
        logic [QW-1:0] q23;
`ifdef SEQ_DIV_ROUND_EN
        q23 = 16'h00AB;
`else
        q23 = 16'h00AA;
`endif
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_q", quotient, 0);
        chk("rst_r", remainder, 0);
        chk("rst_flags", {div_zero, overflow}, 0);
        #2 nrst = 1'b1;
        cmp_en = 1'b1;

        run_op("d100_4", 16'd100, 16'd4, 16'h1900, 16'd0, 1'b0, 1'b0, N);
        run_op("d2_3", 16'd2, 16'd3, q23, 16'd2, 1'b0, 1'b0, N);
        run_op("d5_0", 16'd5, 16'd0, 16'hFFFF, 16'd5, 1'b1, 1'b0, 0);
        run_op("dffff_1", 16'hFFFF, 16'd1, 16'hFFFF, 16'd0, 1'b0, 1'b1, N);

        // Start while busy is ignored, then a back-to-back start in the DONE cycle.
        @(negedge clk);
        start = 1'b1; dividend = 16'd7; divisor = 16'd2;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1; dividend = 16'd9; divisor = 16'd3;
        @(negedge clk);
        start = 1'b0;
        chk("ign_hold_q", quotient, 16'hFFFF);
        wait_done(k);
        chk("ign_lat", k, N - 5);
        chk("ign_q", quotient, 16'h0380);
        start = 1'b1; dividend = 16'd9; divisor = 16'd3;
        @(negedge clk);
        start = 1'b0;
        chk("b2b_prev_q", quotient, 16'h0380);
        wait_done(k);
        chk("b2b_lat", k, N);
        chk("b2b_q", quotient, 16'h0300);

        // Reset in the middle of an operation.
        @(negedge clk);
        start = 1'b1; dividend = 16'd100; divisor = 16'd4;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        #2 nrst = 1'b0;
        #1;
        chk("mrst_busy", busy, 0);
        chk("mrst_done", done, 0);
        chk("mrst_q", quotient, 0);
        chk("mrst_r", remainder, 0);
        @(negedge clk);
        #2 nrst = 1'b1;
        run_op("post_rst", 16'd100, 16'd4, 16'h1900, 16'd0, 1'b0, 1'b0, N);

        // Random traffic: light then heavy start rates, occasional small operands and resets.
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            start = ($urandom_range(0, 99) < ((c < 2000) ? 30 : 90));
            case ($urandom_range(0, 3))
                0: dividend = DW'($urandom_range(0, 31));
                default: dividend = DW'($urandom);
            endcase
            case ($urandom_range(0, 15))
                0: divisor = '0;
                1, 2, 3, 4: divisor = DW'($urandom_range(1, 15));
                5: divisor = DW'($urandom_range(1, 3));
                default: divisor = DW'($urandom);
            endcase
            if ($urandom_range(0, 999) == 0) begin
                #2 nrst = 1'b0;
                @(negedge clk);
                #2 nrst = 1'b1;
            end
        end
        @(negedge clk);
        start = 1'b0;
        repeat (N + 2) @(negedge clk);
        n_chk++;
        if (n_done < 50) begin
            n_fail++;
            $display("FAIL rand_done_count: got %0d expected at least 50", n_done);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
